pipe_stage_chain: RTL and testbench

//  Parametrised pipeline-register chain for the VLIW datapath; successor to the fixed-width IF/ID..MEM/WB latches.

---
 rtl/pipe_stage_chain.sv | 95 +++++++++
 tb/tb_pipe_stage_chain.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised pipeline-register chain carrying a data
// bundle, a control bundle and a valid bit through STAGES registers, with
// per-stage stall/flush, bubble insertion and occupancy reporting.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int STAGES = 2,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [STAGES-1:0] stage_vld,
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             vldQ;
  logic [STAGES-1:0][CTRL_W-1:0] ctrlQ;
  logic [STAGES-1:0][DATA_W-1:0] dataQ;

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    logic              upValid;
    logic [CTRL_W-1:0] upCtrl;
    logic [DATA_W-1:0] upData;
    logic              bubble;
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    // A stall anywhere downstream also freezes this stage.
    assign hold[g] = |stall[STAGES-1:g];

    if (g == 0) begin : gHead
      assign upValid = in_valid;
      assign upCtrl  = in_ctrl;
      assign upData  = in_data;
      assign bubble  = 1'b0;
    end else begin : gBody
      assign upValid = vldQ[g-1];
      assign upCtrl  = ctrlQ[g-1];
      assign upData  = dataQ[g-1];
      // Upstream is held but this stage is free: fill it with a bubble.
      assign bubble  = stall[g-1];
    end

    // Stage register: flush > hold > bubble > load from upstream.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld  <= 1'b0;
        ctrl <= '0;
        data <= '0;
      end else if (flush[g]) begin
        vld  <= 1'b0;
        ctrl <= '0;
      end else if (hold[g]) begin
        vld  <= vld;
      end else if (bubble) begin
        vld  <= 1'b0;
        ctrl <= '0;
      end else begin
        vld  <= upValid;
        ctrl <= upValid ? upCtrl : '0;
        data <= upData;
      end
    end

    assign vldQ[g]  = vld;
    assign ctrlQ[g] = ctrl;
    assign dataQ[g] = data;
  end

  assign in_ready  = ~hold[0];
  assign out_valid = vldQ[STAGES-1];
  assign out_ctrl  = ctrlQ[STAGES-1];
  assign out_data  = dataQ[STAGES-1];
  assign stage_vld = vldQ;

  // Population count of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(vldQ[i]);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (STAGES=3 main instance plus a
// STAGES=1 instance sharing the upstream inputs).
module tb_pipe_stage_chain;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic [31:0] inData;
  logic [7:0]  inCtrl;
  logic [2:0]  stall;
  logic [2:0]  flush;
  logic        inReady;
  logic        outValid;
  logic [31:0] outData;
  logic [7:0]  outCtrl;
  logic [2:0]  stageVld;
  logic [1:0]  occupancy;

  logic        stall1;
  logic        flush1;
  logic        inReady1;
  logic        outValid1;
  logic [31:0] outData1;
  logic [7:0]  outCtrl1;
  logic [0:0]  stageVld1;
  logic [0:0]  occupancy1;

  int errors = 0;
  int checks = 0;

  // Reference model: contents of each of the 3 stages, plus the 1-stage chain.
  logic        mV[3];
  logic [7:0]  mC[3];
  logic [31:0] mD[3];
  logic        pV;
  logic [7:0]  pC;
  logic [31:0] pD;

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .STAGES(3)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData),
    .in_ctrl(inCtrl), .in_ready(inReady), .stall(stall), .flush(flush),
    .out_valid(outValid), .out_data(outData), .out_ctrl(outCtrl),
    .stage_vld(stageVld), .occupancy(occupancy)
  );

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData),
    .in_ctrl(inCtrl), .in_ready(inReady1), .stall(stall1), .flush(flush1),
    .out_valid(outValid1), .out_data(outData1), .out_ctrl(outCtrl1),
    .stage_vld(stageVld1), .occupancy(occupancy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    int occ;
    occ = 0;
    for (int i = 0; i < 3; i++) occ += int'(mV[i]);
    cmp("out_valid", 64'(outValid), 64'(mV[2]));
    cmp("out_ctrl",  64'(outCtrl),  64'(mC[2]));
    cmp("out_data",  64'(outData),  64'(mD[2]));
    cmp("stage_vld", 64'(stageVld), 64'({mV[2], mV[1], mV[0]}));
    cmp("occupancy", 64'(occupancy), 64'(occ));
    cmp("in_ready",  64'(inReady),  64'(stall == 3'b000));
    cmp("s1_valid",  64'(outValid1), 64'(pV));
    cmp("s1_ctrl",   64'(outCtrl1),  64'(pC));
    cmp("s1_data",   64'(outData1),  64'(pD));
    cmp("s1_occ",    64'(occupancy1), 64'(pV));
  endtask

  task automatic zeroModel();
    for (int i = 0; i < 3; i++) begin
      mV[i] = 1'b0; mC[i] = '0; mD[i] = '0;
    end
    pV = 1'b0; pC = '0; pD = '0;
  endtask

  // One clock: derive next stage contents from the stage rules, then compare.
  task automatic tick();
    logic        nV[3];
    logic [7:0]  nC[3];
    logic [31:0] nD[3];
    logic        upV;
    logic [7:0]  upC;
    logic [31:0] upD;
    logic        held;
    for (int i = 0; i < 3; i++) begin
      held = ((stall >> i) != 3'b000);
      upV  = (i == 0) ? inValid : mV[i-1];
      upC  = (i == 0) ? inCtrl  : mC[i-1];
      upD  = (i == 0) ? inData  : mD[i-1];
      nV[i] = mV[i]; nC[i] = mC[i]; nD[i] = mD[i];
      if (flush[i]) begin
        nV[i] = 1'b0; nC[i] = '0;
      end else if (held) begin
        // keep
      end else if (i > 0 && stall[i-1]) begin
        nV[i] = 1'b0; nC[i] = '0;
      end else begin
        nV[i] = upV; nC[i] = upV ? upC : 8'h00; nD[i] = upD;
      end
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      zeroModel();
    end else begin
      for (int i = 0; i < 3; i++) begin
        mV[i] = nV[i]; mC[i] = nC[i]; mD[i] = nD[i];
      end
      pV = inValid; pC = inValid ? inCtrl : 8'h00; pD = inData;
    end
    checkAll();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c);
    inValid = v; inData = d; inCtrl = c;
  endtask

  task automatic asyncReset();
    reset = 1'b0;
    #1;
    zeroModel();
    checkAll();
  endtask

  initial begin
    reset = 1'b1;
    stall = '0; flush = '0; stall1 = 1'b0; flush1 = 1'b0;
    drive(1'b0, '0, '0);
    zeroModel();
    #2;
    asyncReset();
    cmp("rst_occupancy", 64'(occupancy), 64'd0);
    #10 reset = 1'b1;

    // Fill three consecutive instructions.
    drive(1'b1, 32'hA0, 8'h11); tick();
    drive(1'b1, 32'hA1, 8'h12); tick();
    drive(1'b1, 32'hA2, 8'h13); tick();
    cmp("t1_out_data", 64'(outData), 64'hA0);
    cmp("t1_out_ctrl", 64'(outCtrl), 64'h11);
    cmp("t1_occ", 64'(occupancy), 64'd3);
    cmp("t1_lat1_data", 64'(outData1), 64'hA2);

    // Last stage stalled for two cycles: everything frozen.
    drive(1'b1, 32'hA3, 8'h14); stall = 3'b100;
    #1;
    cmp("t2_in_ready", 64'(inReady), 64'd0);
    tick();
    tick();
    cmp("t2_frozen", 64'(outData), 64'hA0);
    stall = 3'b000;
    tick();
    cmp("t2_release", 64'(outData), 64'hA1);
    drive(1'b1, 32'hA4, 8'h15); tick();
    drive(1'b1, 32'hA5, 8'h16); tick();
    cmp("t2_a3_out", 64'(outData), 64'hA3);

    // Middle stage stalled one cycle: bubble into the last stage.
    drive(1'b1, 32'hA6, 8'h17); stall = 3'b010;
    tick();
    cmp("t3_bubble_vld", 64'(outValid), 64'd0);
    cmp("t3_bubble_ctrl", 64'(outCtrl), 64'h00);
    cmp("t3_occ", 64'(occupancy), 64'd2);
    stall = 3'b000;
    tick();
    cmp("t3_resume", 64'(outData), 64'hA4);

    // Flush beats stall.
    drive(1'b1, 32'hA7, 8'h18); flush = 3'b011; stall = 3'b010;
    tick();
    cmp("t4_flushed", 64'(stageVld & 3'b011), 64'd0);
    flush = 3'b000; stall = 3'b000;

    // Invalid input: control zeroed, data still carried.
    drive(1'b0, 32'h1234, 8'hFF); tick();
    drive(1'b0, 32'h0, 8'h00); tick();
    tick();
    cmp("t5_data", 64'(outData), 64'h1234);
    cmp("t5_ctrl", 64'(outCtrl), 64'h00);

    // Reset between edges with a full chain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hB0 + 32'(i), 8'h20 + 8'(i)); tick();
    end
    #2;
    asyncReset();
    cmp("t6_stage_vld", 64'(stageVld), 64'd0);
    tick();
    #2 reset = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom));
      for (int b = 0; b < 3; b++) begin
        stall[b] = ($urandom_range(0, 99) < 15);
        flush[b] = ($urandom_range(0, 99) < 8);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2;
        asyncReset();
        tick();
        #2 reset = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
